vex_bus_env: RTL and testbench

VEX_BUS_ENV -- requirements
Module: vex_bus_env

---
 rtl/vex_bus_env_pkg.sv | 20 ++
 rtl/vex_bus_env_if.sv | 27 ++
 rtl/vex_bus_chan.sv | 72 +++++++
 rtl/vex_bus_env.sv | 45 ++++
 tb/tb_vex_bus_env.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vex_bus_env_pkg.sv
// Shared constants and helpers for the VexRiscv bus environment model.
// Holds the default parameter values and the counter widths used by every channel.
package vex_bus_env_pkg;

  localparam int NCHAN_DEF     = 2;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_STALL_DEF = 4;
  localparam int RSP_DEPTH_DEF = 2;

  localparam int STALL_W = 4;
  localparam int OUT_W   = 3;

  typedef logic [STALL_W-1:0] stall_t;
  typedef logic [OUT_W-1:0]   cnt_t;

  function automatic stall_t stall_next(input stall_t cur, input stall_t max_stall);
    return (cur >= max_stall) ? cur : stall_t'(cur + 1'b1);
  endfunction

endpackage

// File: rtl/vex_bus_env_if.sv
// Bundle of command/response signals between the core (master) and the
// bus environment (slave), one bit or slice per channel.
interface vex_bus_env_if #(
  parameter int NCHAN  = vex_bus_env_pkg::NCHAN_DEF,
  parameter int DATA_W = vex_bus_env_pkg::DATA_W_DEF
) ();

  logic [NCHAN-1:0]                         cmd_valid;
  logic [NCHAN-1:0]                         cmd_ready;
  logic [NCHAN-1:0]                         rand_cmd_ready;
  logic [NCHAN-1:0]                         rand_rsp_valid;
  logic [NCHAN*DATA_W-1:0]                  rand_rsp_data;
  logic [NCHAN-1:0]                         rsp_valid;
  logic [NCHAN*DATA_W-1:0]                  rsp_data;
  logic [NCHAN*vex_bus_env_pkg::OUT_W-1:0]  outstanding;

  modport master (
    output cmd_valid, rand_cmd_ready, rand_rsp_valid, rand_rsp_data,
    input  cmd_ready, rsp_valid, rsp_data, outstanding
  );

  modport slave (
    input  cmd_valid, rand_cmd_ready, rand_rsp_valid, rand_rsp_data,
    output cmd_ready, rsp_valid, rsp_data, outstanding
  );

endinterface

// File: rtl/vex_bus_chan.sv
// One independent bus channel: outstanding-command tracking plus stall counters.
// Define VEXRISCV_FAIRNESS_EN to force a handshake once a stall reaches MAX_STALL.
module vex_bus_chan
  import vex_bus_env_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_STALL = MAX_STALL_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic              rand_cmd_ready,
  input  logic              rand_rsp_valid,
  input  logic [DATA_W-1:0] rand_rsp_data,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output cnt_t              outstanding
);

  localparam stall_t MAX_S = stall_t'(MAX_STALL);
  localparam cnt_t   DEPTH = cnt_t'(RSP_DEPTH);

  cnt_t   out_q, out_d;
  stall_t cmd_stall_q, cmd_stall_d;
  stall_t rsp_stall_q, rsp_stall_d;
  logic   cmd_force, rsp_force, full, accept;

`ifdef VEXRISCV_FAIRNESS_EN
  assign cmd_force = (cmd_stall_q == MAX_S);
  assign rsp_force = (rsp_stall_q == MAX_S);
`else
  assign cmd_force = 1'b0;
  assign rsp_force = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    rsp_valid   = !reset && (out_q != '0) && (rand_rsp_valid || rsp_force);
    full        = (out_q == DEPTH) && !rsp_valid;
    cmd_ready   = !reset && !full && (rand_cmd_ready || cmd_force);
    accept      = cmd_valid && cmd_ready;
    rsp_data    = rsp_valid ? rand_rsp_data : '0;
    outstanding = reset ? '0 : out_q;

    // Count only the net change; the registered count keeps responses at least one cycle after accept.
    out_d = out_q;
    if (accept && !rsp_valid)      out_d = cnt_t'(out_q + 1'b1);
    else if (!accept && rsp_valid) out_d = cnt_t'(out_q - 1'b1);

    cmd_stall_d = (cmd_valid && !cmd_ready) ? stall_next(cmd_stall_q, MAX_S) : '0;

    rsp_stall_d = rsp_stall_q;
    if (rsp_valid)           rsp_stall_d = '0;
    else if (out_q != '0)    rsp_stall_d = stall_next(rsp_stall_q, MAX_S);
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q       <= '0;
      cmd_stall_q <= '0;
      rsp_stall_q <= '0;
    end else begin
      out_q       <= out_d;
      cmd_stall_q <= cmd_stall_d;
      rsp_stall_q <= rsp_stall_d;
    end
  end

endmodule

// File: rtl/vex_bus_env.sv
// Bus environment top: NCHAN independent channels behind one bus interface.
// Fairness forcing is enabled by defining VEXRISCV_FAIRNESS_EN.
module vex_bus_env
  import vex_bus_env_pkg::*;
#(
  parameter int NCHAN     = NCHAN_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_STALL = MAX_STALL_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic          clock,
  input  logic          reset,
  vex_bus_env_if.slave  bus
);

  logic [NCHAN-1:0]        cmd_ready_w;
  logic [NCHAN-1:0]        rsp_valid_w;
  logic [NCHAN*DATA_W-1:0] rsp_data_w;
  logic [NCHAN*OUT_W-1:0]  outstanding_w;

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    vex_bus_chan #(
      .DATA_W    (DATA_W),
      .MAX_STALL (MAX_STALL),
      .RSP_DEPTH (RSP_DEPTH)
    ) u_chan (
      .clock          (clock),
      .reset          (reset),
      .cmd_valid      (bus.cmd_valid[c]),
      .rand_cmd_ready (bus.rand_cmd_ready[c]),
      .rand_rsp_valid (bus.rand_rsp_valid[c]),
      .rand_rsp_data  (bus.rand_rsp_data[c*DATA_W +: DATA_W]),
      .cmd_ready      (cmd_ready_w[c]),
      .rsp_valid      (rsp_valid_w[c]),
      .rsp_data       (rsp_data_w[c*DATA_W +: DATA_W]),
      .outstanding    (outstanding_w[c*OUT_W +: OUT_W])
    );
  end

  assign bus.cmd_ready   = cmd_ready_w;
  assign bus.rsp_valid   = rsp_valid_w;
  assign bus.rsp_data    = rsp_data_w;
  assign bus.outstanding = outstanding_w;

endmodule

// File: tb/tb_vex_bus_env.sv
// Directed self-checking bench for vex_bus_env (NCHAN=2, DATA_W=32, MAX_STALL=4, RSP_DEPTH=2).
// Expectations follow VEXRISCV_FAIRNESS_EN when it is defined for the build.
module tb_vex_bus_env;
  import vex_bus_env_pkg::*;

  localparam int NCHAN     = 2;
  localparam int DATA_W    = 32;
  localparam int MAX_STALL = 4;
  localparam int RSP_DEPTH = 2;

`ifdef VEXRISCV_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vex_bus_env_if #(.NCHAN(NCHAN), .DATA_W(DATA_W)) bus ();

  vex_bus_env #(
    .NCHAN     (NCHAN),
    .DATA_W    (DATA_W),
    .MAX_STALL (MAX_STALL),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [1:0] cv, input logic [1:0] crdy, input logic [1:0] rv,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.cmd_valid      = cv;
    bus.rand_cmd_ready = crdy;
    bus.rand_rsp_valid = rv;
    bus.rand_rsp_data  = {d1, d0};
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(2'b11, 2'b11, 2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    next_cycle();
    next_cycle();
    checks++;
    if (bus.cmd_ready !== 2'b00) begin
      errors++; $display("FAIL reset_cmd_ready got %b want 00", bus.cmd_ready);
    end
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL reset_rsp_valid got %b want 00", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_data !== 64'h0) begin
      errors++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data);
    end
    checks++;
    if (bus.outstanding !== 6'd0) begin
      errors++; $display("FAIL reset_outstanding got %h want 0", bus.outstanding);
    end
    reset = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
  endtask

  // Response gated off with nothing outstanding; first response one cycle after accept.
  task automatic test_rsp_data();
    next_cycle();
    drive(2'b01, 2'b01, 2'b01, 32'hDEAD_BEEF, 32'h0);
    checks++;
    if (bus.cmd_ready[0] !== 1'b1) begin
      errors++; $display("FAIL zero_out_cmd_ready got %b want 1", bus.cmd_ready[0]);
    end
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL zero_out_rsp_valid got %b want 00", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_data !== 64'h0) begin
      errors++; $display("FAIL zero_out_rsp_data got %h want 0", bus.rsp_data);
    end
    next_cycle();
    drive(2'b00, 2'b00, 2'b01, 32'hDEAD_BEEF, 32'h0);
    checks++;
    if (bus.outstanding[2:0] !== 3'd1) begin
      errors++; $display("FAIL accept_outstanding got %0d want 1", bus.outstanding[2:0]);
    end
    checks++;
    if (bus.rsp_valid[0] !== 1'b1) begin
      errors++; $display("FAIL first_rsp_valid got %b want 1", bus.rsp_valid[0]);
    end
    checks++;
    if (bus.rsp_data[31:0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL first_rsp_data got %h want deadbeef", bus.rsp_data[31:0]);
    end
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    checks++;
    if (bus.outstanding !== 6'd0) begin
      errors++; $display("FAIL rsp_drain_outstanding got %h want 0", bus.outstanding);
    end
  endtask

  task automatic test_full();
    next_cycle();
    drive(2'b01, 2'b01, 2'b00, 32'h0, 32'h0);
    next_cycle();
    checks++;
    if (bus.cmd_ready[0] !== 1'b1) begin
      errors++; $display("FAIL second_accept_ready got %b want 1", bus.cmd_ready[0]);
    end
    next_cycle();
    drive(2'b01, 2'b01, 2'b00, 32'h0, 32'h0);
    checks++;
    if (bus.outstanding[2:0] !== 3'd2) begin
      errors++; $display("FAIL full_outstanding got %0d want 2", bus.outstanding[2:0]);
    end
    checks++;
    if (bus.cmd_ready[0] !== 1'b0) begin
      errors++; $display("FAIL full_no_rsp_ready got %b want 0", bus.cmd_ready[0]);
    end
    drive(2'b01, 2'b01, 2'b01, 32'h1234_5678, 32'h0);
    checks++;
    if (bus.cmd_ready[0] !== 1'b1) begin
      errors++; $display("FAIL full_with_rsp_ready got %b want 1", bus.cmd_ready[0]);
    end
    checks++;
    if (bus.rsp_valid[0] !== 1'b1) begin
      errors++; $display("FAIL full_with_rsp_valid got %b want 1", bus.rsp_valid[0]);
    end
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    checks++;
    if (bus.outstanding[2:0] !== 3'd2) begin
      errors++; $display("FAIL full_swap_outstanding got %0d want 2", bus.outstanding[2:0]);
    end
    drive(2'b00, 2'b00, 2'b01, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    checks++;
    if (bus.outstanding !== 6'd0) begin
      errors++; $display("FAIL full_drain_outstanding got %h want 0", bus.outstanding);
    end
  endtask

  task automatic test_cmd_stall();
    for (int k = 1; k <= 5; k++) begin
      logic exp_ready;
      next_cycle();
      drive(2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
      exp_ready = FAIR && (k == 5);
      checks++;
      if (bus.cmd_ready[0] !== exp_ready) begin
        errors++; $display("FAIL cmd_stall_ready cycle %0d got %b want %b", k, bus.cmd_ready[0], exp_ready);
      end
    end
    next_cycle();
    drive(2'b00, 2'b00, 2'b01, 32'h0, 32'h0);
    checks++;
    if (bus.outstanding[2:0] !== 3'(FAIR)) begin
      errors++; $display("FAIL cmd_stall_outstanding got %0d want %0d", bus.outstanding[2:0], FAIR);
    end
    checks++;
    if (bus.rsp_valid[0] !== FAIR) begin
      errors++; $display("FAIL cmd_stall_rsp_valid got %b want %b", bus.rsp_valid[0], FAIR);
    end
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_rsp_stall();
    next_cycle();
    drive(2'b01, 2'b01, 2'b00, 32'h0, 32'h0);
    checks++;
    if (bus.cmd_ready[0] !== 1'b1) begin
      errors++; $display("FAIL rsp_stall_accept got %b want 1", bus.cmd_ready[0]);
    end
    for (int k = 1; k <= 10; k++) begin
      logic exp_valid;
      next_cycle();
      drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
      exp_valid = FAIR && (k == 5);
      checks++;
      if (bus.rsp_valid[0] !== exp_valid) begin
        errors++; $display("FAIL rsp_stall_valid cycle %0d got %b want %b", k, bus.rsp_valid[0], exp_valid);
      end
    end
    next_cycle();
    drive(2'b00, 2'b00, 2'b01, 32'h0, 32'h0);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    checks++;
    if (bus.outstanding !== 6'd0) begin
      errors++; $display("FAIL rsp_stall_drain got %h want 0", bus.outstanding);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    drive(2'b10, 2'b10, 2'b00, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    checks++;
    if (bus.outstanding[5:3] !== 3'd2) begin
      errors++; $display("FAIL mid_pre_outstanding got %0d want 2", bus.outstanding[5:3]);
    end
    reset = 1'b1;
    drive(2'b11, 2'b11, 2'b11, 32'h1111_1111, 32'h2222_2222);
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL mid_reset_rsp_valid got %b want 00", bus.rsp_valid);
    end
    checks++;
    if (bus.cmd_ready !== 2'b00) begin
      errors++; $display("FAIL mid_reset_cmd_ready got %b want 00", bus.cmd_ready);
    end
    next_cycle();
    reset = 1'b0;
    drive(2'b00, 2'b00, 2'b11, 32'h1111_1111, 32'h2222_2222);
    checks++;
    if (bus.outstanding[5:3] !== 3'd0) begin
      errors++; $display("FAIL mid_post_outstanding got %0d want 0", bus.outstanding[5:3]);
    end
    checks++;
    if (bus.rsp_valid[1] !== 1'b0) begin
      errors++; $display("FAIL mid_post_rsp_valid got %b want 0", bus.rsp_valid[1]);
    end
    checks++;
    if (bus.rsp_data !== 64'h0) begin
      errors++; $display("FAIL mid_post_rsp_data got %h want 0", bus.rsp_data);
    end
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
  endtask

  // Channel 0 stalled on commands while channel 1 handshakes every cycle.
  task automatic test_independent();
    for (int k = 0; k < 8; k++) begin
      logic [31:0] d1;
      logic        exp_ready0;
      d1 = 32'h0000_1000 + 32'(k);
      next_cycle();
      drive(2'b11, 2'b10, 2'b10, 32'hFFFF_FFFF, d1);
      exp_ready0 = FAIR && (k == 4);
      checks++;
      if (bus.cmd_ready[1] !== 1'b1) begin
        errors++; $display("FAIL indep_ready1 cycle %0d got %b want 1", k, bus.cmd_ready[1]);
      end
      checks++;
      if (bus.cmd_ready[0] !== exp_ready0) begin
        errors++; $display("FAIL indep_ready0 cycle %0d got %b want %b", k, bus.cmd_ready[0], exp_ready0);
      end
      checks++;
      if (bus.rsp_data[31:0] !== 32'h0) begin
        errors++; $display("FAIL indep_data0 cycle %0d got %h want 0", k, bus.rsp_data[31:0]);
      end
      if (k > 0) begin
        checks++;
        if (bus.rsp_valid[1] !== 1'b1) begin
          errors++; $display("FAIL indep_rsp1 cycle %0d got %b want 1", k, bus.rsp_valid[1]);
        end
        checks++;
        if (bus.rsp_data[63:32] !== d1) begin
          errors++; $display("FAIL indep_data1 cycle %0d got %h want %h", k, bus.rsp_data[63:32], d1);
        end
        checks++;
        if (bus.outstanding[5:3] !== 3'd1) begin
          errors++; $display("FAIL indep_out1 cycle %0d got %0d want 1", k, bus.outstanding[5:3]);
        end
      end else begin
        checks++;
        if (bus.rsp_valid[1] !== 1'b0) begin
          errors++; $display("FAIL indep_rsp1_first got %b want 0", bus.rsp_valid[1]);
        end
      end
    end
    next_cycle();
    drive(2'b00, 2'b00, 2'b11, 32'h0, 32'h0);
    next_cycle();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    checks++;
    if (bus.outstanding !== 6'd0) begin
      errors++; $display("FAIL indep_drain got %h want 0", bus.outstanding);
    end
  endtask

  initial begin
    test_reset();
    test_rsp_data();
    test_full();
    test_cmd_stall();
    test_rsp_stall();
    test_reset_mid();
    test_independent();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
